voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 142 ++++++++++++++
 tb/tb_voice_allocator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice allocator for decoded MIDI note messages.
// Ports: clock_50_000_000/reset_l (sync, active-low); message + message_ready (1-cycle qualifier);
// voice_gate/voice_note/voice_velocity/voice_trigger per voice; busy (LOOKUP/COMMIT); overrun (sticky).

package MIDI;
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;

  typedef struct packed {
    logic [3:0] message_type;  // status high nibble
    logic [3:0] channel;       // ignored: allocator is omni
    logic [6:0] data_byte1;    // note number
    logic [6:0] data_byte2;    // velocity
  } message_t;
endpackage

module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int AGE_W      = 8
) (
  input  logic                             clock_50_000_000,
  input  logic                             reset_l,
  input  MIDI::message_t                   message,
  input  logic                             message_ready,
  output logic [NUM_VOICES-1:0]            voice_gate,
  output logic [NUM_VOICES-1:0][6:0]       voice_note,
  output logic [NUM_VOICES-1:0][6:0]       voice_velocity,
  output logic [NUM_VOICES-1:0]            voice_trigger,
  output logic                             busy,
  output logic                             overrun
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT} state_t;

  state_t                         state, state_next;
  MIDI::message_t                 msg;
  logic [IDX_W-1:0]               target, target_next;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age;

  logic                           is_on, is_off;
  logic                           hit_found, free_found;
  logic [IDX_W-1:0]               hit_idx, free_idx, old_idx;
  logic [AGE_W-1:0]               old_age;

  // Velocity-0 NOTE_ON is a release, as in running-status MIDI streams.
  assign is_on  = (msg.message_type == MIDI::NOTE_ON) && (msg.data_byte2 != 7'd0);
  assign is_off = (msg.message_type == MIDI::NOTE_OFF) ||
                  ((msg.message_type == MIDI::NOTE_ON) && (msg.data_byte2 == 7'd0));

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (message_ready) state_next = LOOKUP;
      LOOKUP:  state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Target search. Scanning high-to-low lets the lowest matching index win.
  // Retrigger takes precedence so a note can never hold two gated voices.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_gate[i] && (voice_note[i] == msg.data_byte1)) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if (!voice_gate[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    // Steal only happens when every voice is gated, so all ages are live.
    // Strict '>' keeps ties on the lowest index.
    old_idx = '0;
    old_age = age[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age[i] > old_age) begin
        old_age = age[i];
        old_idx = IDX_W'(i);
      end
    end
    if (hit_found)       target_next = hit_idx;
    else if (free_found) target_next = free_idx;
    else                 target_next = old_idx;
  end

  always_ff @(posedge clock_50_000_000) begin
    if (!reset_l) begin
      state          <= IDLE;
      msg            <= '0;
      target         <= '0;
      voice_gate     <= '0;
      voice_note     <= '0;
      voice_velocity <= '0;
      voice_trigger  <= '0;
      age            <= '0;
      overrun        <= 1'b0;
    end else begin
      state         <= state_next;
      voice_trigger <= '0;

      if (message_ready) begin
        if (state == IDLE) msg     <= message;
        else               overrun <= 1'b1;
      end

      if (state == LOOKUP) target <= target_next;

      if (state == COMMIT) begin
        if (is_on) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == target) begin
              voice_gate[i]     <= 1'b1;
              voice_note[i]     <= msg.data_byte1;
              voice_velocity[i] <= msg.data_byte2;
              age[i]            <= '0;
            end else if (voice_gate[i] && (age[i] != AGE_MAX)) begin
              age[i] <= age[i] + 1'b1;
            end
          end
          voice_trigger[target] <= 1'b1;
        end else if (is_off) begin
          // Note and velocity stay put so the envelope can release on them.
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_note[i] == msg.data_byte1) voice_gate[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

  localparam int NV = 4;

  logic                 clk;
  logic                 reset_l;
  MIDI::message_t       message;
  logic                 message_ready;
  logic [NV-1:0]        voice_gate;
  logic [NV-1:0][6:0]   voice_note;
  logic [NV-1:0][6:0]   voice_velocity;
  logic [NV-1:0]        voice_trigger;
  logic                 busy;
  logic                 overrun;

  typedef struct packed {
    logic [3:0]  gate;
    logic [27:0] note;
    logic [27:0] vel;
    logic [3:0]  trig;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bc;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
    .clock_50_000_000 (clk),
    .reset_l          (reset_l),
    .message          (message),
    .message_ready    (message_ready),
    .voice_gate       (voice_gate),
    .voice_note       (voice_note),
    .voice_velocity   (voice_velocity),
    .voice_trigger    (voice_trigger),
    .busy             (busy),
    .overrun          (overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pulse one message and wait (bounded) for busy to drop. bc = busy cycles, -1 on timeout.
  task automatic drive_msg(input logic [3:0] t, input logic [6:0] n, input logic [6:0] v,
                           output int cyc);
    @(negedge clk);
    message       = '{message_type: t, channel: 4'd3, data_byte1: n, data_byte2: v};
    message_ready = 1'b1;
    @(negedge clk);
    message_ready = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 20) cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_l = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_l = 1'b0;
    message_ready = 1'b1;  // coincident with reset: must be discarded
    message = '{message_type: MIDI::NOTE_ON, channel: 4'd0, data_byte1: 7'd50, data_byte2: 7'd10};
    @(negedge clk);
    message_ready = 1'b0;
    n_cmp++;
    if ({voice_gate, voice_note, voice_velocity, voice_trigger} !== '0) begin
      n_bad++; $display("FAIL reset_voices: got %h want 0", {voice_gate, voice_note, voice_velocity, voice_trigger});
    end
    n_cmp++;
    if ({busy, overrun} !== 2'b00) begin
      n_bad++; $display("FAIL reset_flags: got busy/overrun %b want 00", {busy, overrun});
    end
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || voice_gate !== 4'b0000) begin
      n_bad++; $display("FAIL reset_coincident_drop: got busy %b gate %b want 0 0000", busy, voice_gate);
    end
  endtask

  task automatic test_single_note();
    do_reset();
    sb.push_back('{gate: 4'b0001, note: {7'd0, 7'd0, 7'd0, 7'd60},
                   vel: {7'd0, 7'd0, 7'd0, 7'd100}, trig: 4'b0001});
    drive_msg(MIDI::NOTE_ON, 7'd60, 7'd100, bc);
    n_cmp++;
    if (bc !== 2) begin n_bad++; $display("FAIL single_busy_cycles: got %0d want 2", bc); end
    e = sb.pop_front();
    n_cmp++;
    if (voice_gate !== e.gate) begin n_bad++; $display("FAIL single_gate: got %b want %b", voice_gate, e.gate); end
    n_cmp++;
    if (voice_note !== e.note) begin n_bad++; $display("FAIL single_note: got %h want %h", voice_note, e.note); end
    n_cmp++;
    if (voice_velocity !== e.vel) begin n_bad++; $display("FAIL single_vel: got %h want %h", voice_velocity, e.vel); end
    n_cmp++;
    if (voice_trigger !== e.trig) begin n_bad++; $display("FAIL single_trig: got %b want %b", voice_trigger, e.trig); end
    @(negedge clk);
    n_cmp++;
    if (voice_trigger !== 4'b0000) begin n_bad++; $display("FAIL single_trig_width: got %b want 0000", voice_trigger); end
  endtask

  task automatic test_steal();
    logic [6:0] notes [4];
    notes = '{7'd60, 7'd62, 7'd64, 7'd65};
    do_reset();
    for (int i = 0; i < 4; i++) drive_msg(MIDI::NOTE_ON, notes[i], 7'd100, bc);
    n_cmp++;
    if (voice_gate !== 4'b1111) begin n_bad++; $display("FAIL steal_fill_gate: got %b want 1111", voice_gate); end
    sb.push_back('{gate: 4'b1111, note: {7'd65, 7'd64, 7'd62, 7'd67},
                   vel: {7'd100, 7'd100, 7'd100, 7'd90}, trig: 4'b0001});
    drive_msg(MIDI::NOTE_ON, 7'd67, 7'd90, bc);
    e = sb.pop_front();
    n_cmp++;
    if (voice_note !== e.note) begin n_bad++; $display("FAIL steal_note: got %h want %h", voice_note, e.note); end
    n_cmp++;
    if (voice_velocity !== e.vel) begin n_bad++; $display("FAIL steal_vel: got %h want %h", voice_velocity, e.vel); end
    n_cmp++;
    if (voice_trigger !== e.trig) begin n_bad++; $display("FAIL steal_trig: got %b want %b", voice_trigger, e.trig); end
    // Voice 1 (62) is now the oldest: next steal must land there.
    sb.push_back('{gate: 4'b1111, note: {7'd65, 7'd64, 7'd72, 7'd67},
                   vel: {7'd100, 7'd100, 7'd33, 7'd90}, trig: 4'b0010});
    drive_msg(MIDI::NOTE_ON, 7'd72, 7'd33, bc);
    e = sb.pop_front();
    n_cmp++;
    if (voice_note !== e.note || voice_trigger !== e.trig) begin
      n_bad++; $display("FAIL steal_second: got %h/%b want %h/%b", voice_note, voice_trigger, e.note, e.trig);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    drive_msg(MIDI::NOTE_ON, 7'd60, 7'd100, bc);
    sb.push_back('{gate: 4'b0001, note: {7'd0, 7'd0, 7'd0, 7'd60},
                   vel: {7'd0, 7'd0, 7'd0, 7'd50}, trig: 4'b0001});
    drive_msg(MIDI::NOTE_ON, 7'd60, 7'd50, bc);
    e = sb.pop_front();
    n_cmp++;
    if (voice_gate !== e.gate) begin n_bad++; $display("FAIL retrig_gate: got %b want %b", voice_gate, e.gate); end
    n_cmp++;
    if (voice_velocity !== e.vel) begin n_bad++; $display("FAIL retrig_vel: got %h want %h", voice_velocity, e.vel); end
    n_cmp++;
    if (voice_trigger !== e.trig) begin n_bad++; $display("FAIL retrig_trig: got %b want %b", voice_trigger, e.trig); end
  endtask

  task automatic test_note_off();
    do_reset();
    drive_msg(MIDI::NOTE_ON, 7'd60, 7'd100, bc);
    drive_msg(MIDI::NOTE_ON, 7'd62, 7'd100, bc);
    sb.push_back('{gate: 4'b0001, note: {7'd0, 7'd0, 7'd62, 7'd60},
                   vel: {7'd0, 7'd0, 7'd100, 7'd100}, trig: 4'b0000});
    drive_msg(MIDI::NOTE_ON, 7'd62, 7'd0, bc);
    e = sb.pop_front();
    n_cmp++;
    if ({voice_gate, voice_note, voice_velocity, voice_trigger} !== {e.gate, e.note, e.vel, e.trig}) begin
      n_bad++; $display("FAIL vel0_off: got %b %h %h %b want %b %h %h %b", voice_gate, voice_note,
                        voice_velocity, voice_trigger, e.gate, e.note, e.vel, e.trig);
    end
    // Unmatched NOTE_OFF and a control change leave everything alone.
    drive_msg(MIDI::NOTE_OFF, 7'd99, 7'd64, bc);
    drive_msg(4'hB, 7'd60, 7'd0, bc);
    n_cmp++;
    if ({voice_gate, voice_note, voice_trigger} !== {4'b0001, 7'd0, 7'd0, 7'd62, 7'd60, 4'b0000}) begin
      n_bad++; $display("FAIL off_nomatch: got %b %h %b want 0001 unchanged", voice_gate, voice_note, voice_trigger);
    end
    sb.push_back('{gate: 4'b0011, note: {7'd0, 7'd0, 7'd70, 7'd60},
                   vel: {7'd0, 7'd0, 7'd80, 7'd100}, trig: 4'b0010});
    drive_msg(MIDI::NOTE_ON, 7'd70, 7'd80, bc);
    e = sb.pop_front();
    n_cmp++;
    if ({voice_gate, voice_note, voice_velocity, voice_trigger} !== {e.gate, e.note, e.vel, e.trig}) begin
      n_bad++; $display("FAIL reuse_freed: got %b %h %h %b want %b %h %h %b", voice_gate, voice_note,
                        voice_velocity, voice_trigger, e.gate, e.note, e.vel, e.trig);
    end
    // Explicit NOTE_OFF type for the held note.
    drive_msg(MIDI::NOTE_OFF, 7'd60, 7'd0, bc);
    n_cmp++;
    if (voice_gate !== 4'b0010 || voice_note[0] !== 7'd60) begin
      n_bad++; $display("FAIL note_off: got gate %b note0 %0d want 0010 60", voice_gate, voice_note[0]);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    @(negedge clk);
    message = '{message_type: MIDI::NOTE_ON, channel: 4'd0, data_byte1: 7'd60, data_byte2: 7'd100};
    message_ready = 1'b1;
    @(negedge clk);
    message_ready = 1'b0;
    @(negedge clk);
    message = '{message_type: MIDI::NOTE_ON, channel: 4'd0, data_byte1: 7'd62, data_byte2: 7'd100};
    message_ready = 1'b1;  // lands while in COMMIT
    @(negedge clk);
    message_ready = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
    n_cmp++;
    if (voice_gate !== 4'b0001 || voice_note[0] !== 7'd60 || busy !== 1'b0) begin
      n_bad++; $display("FAIL overrun_drop: got gate %b busy %b want 0001 0", voice_gate, busy);
    end
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_clear: got %b want 0", overrun); end
  endtask

  task automatic test_reset_commit();
    do_reset();
    @(negedge clk);
    message = '{message_type: MIDI::NOTE_ON, channel: 4'd0, data_byte1: 7'd60, data_byte2: 7'd100};
    message_ready = 1'b1;
    @(negedge clk);
    message_ready = 1'b0;
    @(negedge clk);   // now in COMMIT
    reset_l = 1'b0;
    @(negedge clk);
    reset_l = 1'b1;
    n_cmp++;
    if ({voice_gate, voice_note, voice_velocity, voice_trigger, busy} !== '0) begin
      n_bad++; $display("FAIL reset_in_commit: got gate %b trig %b busy %b want all 0", voice_gate, voice_trigger, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (voice_trigger !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_commit_after: got trig %b busy %b want 0000 0", voice_trigger, busy);
    end
    drive_msg(MIDI::NOTE_ON, 7'd64, 7'd20, bc);
    n_cmp++;
    if (bc !== 2 || voice_gate !== 4'b0001 || voice_note[0] !== 7'd64 || voice_trigger !== 4'b0001) begin
      n_bad++; $display("FAIL reset_commit_recover: got bc %0d gate %b note0 %0d trig %b want 2 0001 64 0001",
                        bc, voice_gate, voice_note[0], voice_trigger);
    end
  endtask

  initial begin
    reset_l       = 1'b0;
    message_ready = 1'b0;
    message       = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_note();
    test_steal();
    test_retrigger();
    test_note_off();
    test_overrun();
    test_reset_commit();
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
